// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the two-digit BCD stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        LAP    = 2'd3
    } sw_state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Returns {carry, next_digit}; anything at or above 9 wraps to 0.
    function automatic logic [4:0] bcd_inc(input logic [3:0] digit);
        if (digit >= BCD_MAX) begin
            return {1'b1, 4'd0};
        end
        return {1'b0, digit + 4'd1};
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and display-side outputs of the stopwatch controller.
interface stopwatch_ctrl_if;

    logic       btn_startstop;
    logic       btn_lap;
    logic       btn_clear;
    logic [7:0] value;
    logic       running;
    logic       lap_active;
    logic       overflow;

    modport master (
        output btn_startstop, btn_lap, btn_clear,
        input  value, running, lap_active, overflow
    );

    modport slave (
        input  btn_startstop, btn_lap, btn_clear,
        output value, running, lap_active, overflow
    );

endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// Two-flop synchronizer plus stable-count debouncer with a registered rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);
    import stopwatch_pkg::*;

    localparam int unsigned       CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]     CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_level_d;
    logic          r_rise;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync    <= '0;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], btn_raw};
            // Any sample agreeing with the accepted level restarts the run of differing samples.
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
        end
    end

    assign level      = r_level;
    assign rise_pulse = r_rise;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Button-sequenced two-digit BCD stopwatch: prescaler, FSM, BCD counter and registered display outputs.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_CYCLES     = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             resetn,
    stopwatch_ctrl_if.slave  bus
);

    localparam int unsigned   PW         = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    logic w_ss_pulse, w_lap_pulse, w_clr_pulse;
    logic w_do_ss, w_do_lap, w_do_clr;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk(clk), .resetn(resetn), .btn_raw(bus.btn_startstop),
        .level(), .rise_pulse(w_ss_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
        .clk(clk), .resetn(resetn), .btn_raw(bus.btn_lap),
        .level(), .rise_pulse(w_lap_pulse)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
        .clk(clk), .resetn(resetn), .btn_raw(bus.btn_clear),
        .level(), .rise_pulse(w_clr_pulse)
    );

    // Only the highest-priority pulse survives; losers are dropped even if the winner is ignored.
    assign w_do_clr = w_clr_pulse;
    assign w_do_ss  = w_ss_pulse  & ~w_clr_pulse;
    assign w_do_lap = w_lap_pulse & ~w_ss_pulse & ~w_clr_pulse;

    sw_state_e     r_state, w_state_n;
    logic [PW-1:0] r_presc, w_presc_n;
    logic [3:0]    r_ones, r_tens, w_ones_n, w_tens_n;
    logic [7:0]    r_lap, w_lap_n;
    logic          r_ovf, w_ovf_n;
    logic [7:0]    r_value;
    logic          r_running, r_lap_active;
    logic [4:0]    w_inc_ones, w_inc_tens;
    logic          w_counting;

    assign w_inc_ones = bcd_inc(r_ones);
    assign w_inc_tens = bcd_inc(r_tens);
    assign w_counting = (r_state == RUN) || (r_state == LAP);

    always_comb begin
        w_state_n = r_state;
        w_presc_n = r_presc;
        w_ones_n  = r_ones;
        w_tens_n  = r_tens;
        w_lap_n   = r_lap;
        w_ovf_n   = r_ovf;

        if (w_counting) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_n = '0;
                w_ones_n  = w_inc_ones[3:0];
                if (w_inc_ones[4]) begin
                    w_tens_n = w_inc_tens[3:0];
                    if (w_inc_tens[4]) begin
                        w_ovf_n = 1'b1;
                    end
                end
            end else begin
                w_presc_n = r_presc + 1'b1;
            end
        end

        case (r_state)
            IDLE: begin
                if (w_do_ss) w_state_n = RUN;
            end
            RUN: begin
                if (w_do_ss) begin
                    w_state_n = PAUSED;
                end else if (w_do_lap) begin
                    w_state_n = LAP;
                    w_lap_n   = {r_tens, r_ones};
                end
            end
            LAP: begin
                if (w_do_ss)       w_state_n = PAUSED;
                else if (w_do_lap) w_state_n = RUN;
            end
            PAUSED: begin
                if (w_do_clr) begin
                    w_state_n = IDLE;
                    w_presc_n = '0;
                    w_ones_n  = '0;
                    w_tens_n  = '0;
                    w_ovf_n   = 1'b0;
                end else if (w_do_ss) begin
                    w_state_n = RUN;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Outputs are derived from next-state values so they change on the same edge as the event.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_presc      <= '0;
            r_ones       <= '0;
            r_tens       <= '0;
            r_lap        <= '0;
            r_ovf        <= 1'b0;
            r_value      <= '0;
            r_running    <= 1'b0;
            r_lap_active <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_presc      <= w_presc_n;
            r_ones       <= w_ones_n;
            r_tens       <= w_tens_n;
            r_lap        <= w_lap_n;
            r_ovf        <= w_ovf_n;
            r_value      <= (w_state_n == LAP) ? w_lap_n : {w_tens_n, w_ones_n};
            r_running    <= (w_state_n == RUN) || (w_state_n == LAP);
            r_lap_active <= (w_state_n == LAP);
        end
    end

    assign bus.value      = r_value;
    assign bus.running    = r_running;
    assign bus.lap_active = r_lap_active;
    assign bus.overflow   = r_ovf;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_CYCLES=4, DEBOUNCE_CYCLES=3.
module tb_stopwatch_ctrl;

    logic clk;
    logic resetn;
    int   vectors;
    int   miscompares;
    logic [10:0] obs;

    stopwatch_ctrl_if sw_if ();

    stopwatch_ctrl #(.TICK_CYCLES(4), .DEBOUNCE_CYCLES(3)) dut (
        .clk(clk),
        .resetn(resetn),
        .bus(sw_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // sel = {clear, startstop, lap}; press acts on the 7th edge, returns just after it.
    task automatic press(input logic [2:0] sel);
        sw_if.btn_clear     = sel[2];
        sw_if.btn_startstop = sel[1];
        sw_if.btn_lap       = sel[0];
        cyc(5);
        sw_if.btn_clear     = 1'b0;
        sw_if.btn_startstop = 1'b0;
        sw_if.btn_lap       = 1'b0;
        cyc(2);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 resetn = 1'b0;
        sw_if.btn_clear = 1'b0; sw_if.btn_startstop = 1'b0; sw_if.btn_lap = 1'b0;
        #3 resetn = 1'b1;
        cyc(4);
    endtask

    // obs layout: {value[7:0], running, lap_active, overflow}
    task automatic test_reset();
        resetn = 1'b0;
        sw_if.btn_clear = 1'b0; sw_if.btn_startstop = 1'b0; sw_if.btn_lap = 1'b0;
        #1;
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_state got=%h exp=%h", obs, 11'h000);
        end
        @(negedge clk);
        resetn = 1'b1;
        cyc(2);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_release got=%h exp=%h", obs, 11'h000);
        end
    endtask

    task automatic test_glitch();
        sw_if.btn_startstop = 1'b1;
        cyc(2);
        sw_if.btn_startstop = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            vectors++;
            if ({sw_if.value, sw_if.running} !== 9'h000) begin
                miscompares++;
                $display("FAIL glitch_c%0d got=%h exp=%h", k, {sw_if.value, sw_if.running}, 9'h000);
            end
        end
    endtask

    task automatic test_start_hold();
        logic [8:0] exp;
        sw_if.btn_startstop = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (k == 10) sw_if.btn_startstop = 1'b0;
            if (k >= 7) exp = {8'((k - 7) / 4), 1'b1};
            else        exp = 9'h000;
            vectors++;
            if ({sw_if.value, sw_if.running} !== exp) begin
                miscompares++;
                $display("FAIL start_c%0d got=%h exp=%h", k, {sw_if.value, sw_if.running}, exp);
            end
        end
    endtask

    // Time references below are edges after entering RUN (E0); ticks fall on E0+4m.
    task automatic test_lap();
        press(3'b010);
        cyc(43);
        press(3'b001);                       // acts at E0+50, live digits 12
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h12, 3'b110}) begin
            miscompares++;
            $display("FAIL lap_enter got=%h exp=%h", obs, {8'h12, 3'b110});
        end
        cyc(6);                              // E0+56, live 14, display frozen
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h12, 3'b110}) begin
            miscompares++;
            $display("FAIL lap_frozen got=%h exp=%h", obs, {8'h12, 3'b110});
        end
        press(3'b001);                       // acts at E0+63, live 15
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h15, 3'b100}) begin
            miscompares++;
            $display("FAIL lap_exit got=%h exp=%h", obs, {8'h15, 3'b100});
        end
        cyc(1);                              // E0+64 tick
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h16, 3'b100}) begin
            miscompares++;
            $display("FAIL lap_live got=%h exp=%h", obs, {8'h16, 3'b100});
        end
    endtask

    task automatic test_overflow();
        cyc(335);                            // E0+399
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h99, 3'b100}) begin
            miscompares++;
            $display("FAIL ovf_before got=%h exp=%h", obs, {8'h99, 3'b100});
        end
        cyc(1);                              // E0+400 wrap
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h00, 3'b101}) begin
            miscompares++;
            $display("FAIL ovf_wrap got=%h exp=%h", obs, {8'h00, 3'b101});
        end
        cyc(4);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h01, 3'b101}) begin
            miscompares++;
            $display("FAIL ovf_continue got=%h exp=%h", obs, {8'h01, 3'b101});
        end
    endtask

    task automatic test_clear_pause();
        press(3'b100);                       // E0+411, clear ignored in RUN
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h02, 3'b101}) begin
            miscompares++;
            $display("FAIL clear_in_run got=%h exp=%h", obs, {8'h02, 3'b101});
        end
        cyc(4);
        press(3'b010);                       // E0+422 -> PAUSED, prescaler held at 2
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h05, 3'b001}) begin
            miscompares++;
            $display("FAIL pause got=%h exp=%h", obs, {8'h05, 3'b001});
        end
        cyc(8);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h05, 3'b001}) begin
            miscompares++;
            $display("FAIL pause_hold got=%h exp=%h", obs, {8'h05, 3'b001});
        end
        press(3'b010);                       // E0+437 resume
        cyc(1);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h05, 3'b101}) begin
            miscompares++;
            $display("FAIL resume_pre got=%h exp=%h", obs, {8'h05, 3'b101});
        end
        cyc(1);                              // tick 2 clocks after resume
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h06, 3'b101}) begin
            miscompares++;
            $display("FAIL resume_tick got=%h exp=%h", obs, {8'h06, 3'b101});
        end
        cyc(2);
        press(3'b010);                       // E0+448 -> PAUSED at 08
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h08, 3'b001}) begin
            miscompares++;
            $display("FAIL pause2 got=%h exp=%h", obs, {8'h08, 3'b001});
        end
        cyc(4);
        press(3'b110);                       // clear beats startstop
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL clear_pause got=%h exp=%h", obs, 11'h000);
        end
        cyc(10);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL clear_idle_hold got=%h exp=%h", obs, 11'h000);
        end
    endtask

    task automatic test_async_reset();
        press(3'b010);
        cyc(6);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== {8'h01, 3'b100}) begin
            miscompares++;
            $display("FAIL arst_pre got=%h exp=%h", obs, {8'h01, 3'b100});
        end
        #3 resetn = 1'b0;
        #1;
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL arst_immediate got=%h exp=%h", obs, 11'h000);
        end
        #2 resetn = 1'b1;
        cyc(20);
        obs = {sw_if.value, sw_if.running, sw_if.lap_active, sw_if.overflow};
        vectors++;
        if (obs !== 11'h000) begin
            miscompares++;
            $display("FAIL arst_after got=%h exp=%h", obs, 11'h000);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_glitch();
        test_start_hold();
        do_reset();
        test_lap();
        test_overflow();
        test_clear_pause();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
